fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Read-side companion to the team's synchronous FIFO. Drains a show-ahead FIFO and emits data as length-delimited bursts on a registered valid/ready stream, with a last flag on the final beat.
- Full bursts start once enough data is buffered. A timeout flushes partial bursts so trickle traffic is not stranded.
- Sits between the sync FIFO read port and a downstream burst consumer, such as a DMA write engine or a packetizer.

Parameters:
- WIDTH, 32, data width; must equal the FIFO WIDTH.
- FIFO_DEPTH, 32, depth of the attached FIFO; sets the fifo_count width.
- BURST_LEN, 8, maximum beats per burst; range 1..FIFO_DEPTH.
- TIMEOUT_CYCLES, 64, idle cycles with a partial level before a flush burst; 0 disables flushing.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, permits new bursts to start; an in-flight burst always completes.
- fifo_empty, input, 1, FIFO empty flag.
- fifo_count, input, $clog2(FIFO_DEPTH+1), FIFO occupancy.
- fifo_dout, input, WIDTH, FIFO head word; valid whenever !fifo_empty (show-ahead).
- fifo_rd_en, output, 1, pops the FIFO head at the clock edge.
- m_valid, output, 1, output beat valid.
- m_ready, input, 1, downstream accepts the beat when m_valid && m_ready.
- m_data, output, WIDTH, beat data.
- m_last, output, 1, final beat of the burst.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Reset and clocking:
  - Single clock domain. Reset is synchronous and active-high.
  - Reset values: fifo_rd_en=0, m_valid=0, m_last=0, m_data=0, busy=0. The FSM returns to IDLE and all counters clear.
  - Reset mid-burst discards any buffered beats. The FIFO is reset by the same rst.
- FSM states and transitions:
  - IDLE:
    - The timeout counter increments while enable && 0 < fifo_count < BURST_LEN. It clears otherwise, and whenever a burst starts.
    - Full burst: if enable && fifo_count >= BURST_LEN, latch burst_len=BURST_LEN and go to ISSUE.
    - Flush burst: otherwise, if TIMEOUT_CYCLES != 0 && timeout counter == TIMEOUT_CYCLES-1 && enable && fifo_count > 0, latch burst_len=fifo_count and go to ISSUE.
  - ISSUE:
    - Pops exactly burst_len words, at most one per cycle.
    - After the pop with issued == burst_len-1, go to DRAIN.
  - DRAIN:
    - Wait until the beat carrying m_last is accepted (m_valid && m_ready && m_last), then go to IDLE.
    - A new burst may start in the cycle after returning to IDLE.
- Pop rule:
  - fifo_rd_en = (state == ISSUE) && !fifo_empty && (occupancy < 2).
  - fifo_rd_en has no combinational path from m_ready.
  - fifo_rd_en is never asserted while fifo_empty is high, so the FIFO error checker must never fire.
  - A popped word enters the output buffer on the same edge.
  - The buffer entry's last bit is set iff this pop is the burst's final pop (issued == burst_len-1).
- Output buffer:
  - Two-entry skid buffer with registered outputs; m_data and m_last come from the head entry.
  - occupancy_next = occupancy + push - (m_valid && m_ready).
  - Simultaneous push and pop keeps occupancy unchanged and preserves order.
  - m_valid = (occupancy != 0).
  - Once m_valid is high, m_data and m_last hold stable until accepted.
- Latency and throughput:
  - From the IDLE start decision, the first fifo_rd_en is in the next cycle. The first m_valid follows one cycle after that pop.
  - Sustained throughput is 1 beat/cycle with m_ready held high.
- Counters and wrap:
  - issued counter width is $clog2(BURST_LEN+1).
  - The timeout counter saturates at TIMEOUT_CYCLES-1 and does not wrap.
- enable deassertion:
  - Mid-burst, it has no effect on the burst in progress.
  - In IDLE, it blocks burst start and clears the timeout counter.
- Bursts never exceed BURST_LEN beats, and every burst ends with exactly one m_last.

Test Plan:
- Full burst: BURST_LEN=8; write 8 words 0x10..0x17 with m_ready=1 → 8 consecutive m_valid beats; m_last only on 0x17; busy falls after the last beat; fifo_rd_en exactly 8 cycles.
- Backpressure: 16 words queued, m_ready toggling 1/0 each cycle → two bursts of 8; data order intact; m_data stable while stalled; fifo_rd_en stops while occupancy == 2.
- Timeout flush: TIMEOUT_CYCLES=64; write 3 words then idle → burst starts after 64 idle cycles; 3 beats with m_last on the 3rd. With TIMEOUT_CYCLES=0 and the same stimulus → no output ever.
- enable gating: 12 words queued with enable=0 → no pops. Raise enable → one 8-beat burst. Drop enable during beat 4 → burst completes all 8 beats, then no further burst.
- Reset mid-burst: assert rst during ISSUE with 2 beats buffered → next cycle m_valid=0, m_last=0, busy=0, fifo_rd_en=0. After reset, new data bursts normally.
- Error freedom: random writes and random m_ready for 10k cycles → fifo_rd_en never high while fifo_empty; no burst longer than BURST_LEN; exactly one m_last per burst.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Drains a show-ahead FIFO into length-delimited bursts on a valid/ready stream.
// Full bursts start at BURST_LEN buffered words; a timeout flushes partial levels.
module fifo_burst_reader #(
    parameter int WIDTH          = 32,
    parameter int FIFO_DEPTH     = 32,
    parameter int BURST_LEN      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             fifo_empty,
    input  logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    input  logic [WIDTH-1:0]                 fifo_dout,
    output logic                             fifo_rd_en,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [WIDTH-1:0]                 m_data,
    output logic                             m_last,
    output logic                             busy,
    output logic [1:0]                       dbg_state
);

    // Stream handshake: a beat transfers on any rising edge where m_valid && m_ready.
    // m_valid never depends on m_ready, and m_data/m_last hold while m_valid && !m_ready.

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(BURST_LEN + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] BURST_LEN_C = CW'(BURST_LEN);
    localparam logic [IW-1:0] BURST_LEN_I = IW'(BURST_LEN);
    localparam logic [TW-1:0] TIMEOUT_MAX = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit            FLUSH_EN    = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [IW-1:0]    burst_len;
    logic [IW-1:0]    issued;
    logic [TW-1:0]    tcnt;
    logic [1:0]       occ;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             last0;
    logic             last1;

    logic has_data;
    logic partial;
    logic start_full;
    logic start_flush;
    logic push;
    logic final_pop;
    logic accept;

    assign has_data    = (fifo_count != '0);
    assign partial     = enable && has_data && (fifo_count < BURST_LEN_C);
    assign start_full  = (state == S_IDLE) && enable && (fifo_count >= BURST_LEN_C);
    assign start_flush = (state == S_IDLE) && !start_full && FLUSH_EN &&
                         (tcnt == TIMEOUT_MAX) && enable && has_data;

    // Pops look only at registered occupancy, so m_ready never reaches fifo_rd_en.
    assign push      = (state == S_ISSUE) && !fifo_empty && (occ < 2'd2);
    assign final_pop = push && (issued == burst_len - IW'(1));
    assign accept    = m_valid && m_ready;

    assign fifo_rd_en = push;
    assign m_valid    = (occ != 2'd0);
    assign m_data     = data0;
    assign m_last     = last0;
    assign busy       = (state != S_IDLE);
    assign dbg_state  = state;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_full || start_flush) state_next = S_ISSUE;
            S_ISSUE: if (final_pop)                 state_next = S_DRAIN;
            S_DRAIN: if (accept && m_last)          state_next = S_IDLE;
            default:                                state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            burst_len <= '0;
            issued    <= '0;
            tcnt      <= '0;
        end else begin
            state <= state_next;

            if (start_full) begin
                burst_len <= BURST_LEN_I;
            end else if (start_flush) begin
                burst_len <= IW'(fifo_count);
            end

            if (state == S_IDLE) begin
                issued <= '0;
            end else if (push) begin
                issued <= issued + IW'(1);
            end

            // Idle timer only runs while a partial level waits in IDLE, saturating at its limit.
            if ((state != S_IDLE) || start_full || start_flush || !partial) begin
                tcnt <= '0;
            end else if (tcnt != TIMEOUT_MAX) begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

    // Two-entry skid buffer; entry 0 is the head driving the stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ   <= 2'd0;
            data0 <= '0;
            last0 <= 1'b0;
            data1 <= '0;
            last1 <= 1'b0;
        end else begin
            case ({push, accept})
                2'b10: begin
                    if (occ == 2'd0) begin
                        data0 <= fifo_dout;
                        last0 <= final_pop;
                    end else begin
                        data1 <= fifo_dout;
                        last1 <= final_pop;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd2) begin
                        data0 <= data1;
                        last0 <= last1;
                    end else begin
                        last0 <= 1'b0;
                    end
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd2) begin
                        data0 <= data1;
                        last0 <= last1;
                        data1 <= fifo_dout;
                        last1 <= final_pop;
                    end else begin
                        data0 <= fifo_dout;
                        last0 <= final_pop;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO environment, a burst-level reference
// model compared every cycle, and directed phases with literal expectations.
module tb_fifo_burst_reader;

    localparam int W     = 32;
    localparam int DEPTH = 32;
    localparam int BL    = 8;
    localparam int TO    = 64;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_DRAIN = 2;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          enable;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [W-1:0]  fifo_dout;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic          busy;
    logic [1:0]    dbg_state;

    logic          rd0, v0, l0, b0;
    logic [W-1:0]  d0;
    logic [1:0]    s0;

    fifo_burst_reader #(.WIDTH(W), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL), .TIMEOUT_CYCLES(TO)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_count(fifo_count), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .dbg_state(dbg_state)
    );

    // Flushing disabled; it sits on a constant 3-word level and must never act.
    fifo_burst_reader #(.WIDTH(W), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL), .TIMEOUT_CYCLES(0)) u_dut_noflush (
        .clk(clk), .rst(rst), .enable(1'b1), .fifo_empty(1'b0),
        .fifo_count(CW'(3)), .fifo_dout(32'hdead_beef), .fifo_rd_en(rd0),
        .m_valid(v0), .m_ready(1'b1), .m_data(d0), .m_last(l0),
        .busy(b0), .dbg_state(s0)
    );

    // FIFO environment, model and scoreboard state
    logic [W-1:0] fq[$];
    logic [W:0]   exp_q[$];
    logic [W:0]   acc_q[$];
    int ph, left_cnt, idle_cnt;
    int n_cmp, n_err, cyc;
    int rd_cnt, first_rd_cyc, first_acc_cyc, last_acc_cyc, burst_beats, base;
    bit noflush_active;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_stats();
        acc_q.delete();
        rd_cnt        = 0;
        first_rd_cyc  = -1;
        first_acc_cyc = -1;
        last_acc_cyc  = -1;
        base          = cyc;
    endtask

    // Reference model: advances one clock using the rules in burst terms.
    task automatic model_update(input bit pop, input bit acc);
        int   c;
        logic new_last;
        if (rst) begin
            ph = P_IDLE; left_cnt = 0; idle_cnt = 0;
            exp_q.delete();
            return;
        end
        c        = fq.size();
        new_last = 1'b0;
        case (ph)
            P_IDLE: begin
                if (enable && c >= BL) begin
                    left_cnt = BL; ph = P_ISSUE; idle_cnt = 0;
                end else if (TO != 0 && idle_cnt == TO - 1 && enable && c > 0) begin
                    left_cnt = c; ph = P_ISSUE; idle_cnt = 0;
                end else if (enable && c > 0 && c < BL) begin
                    if (idle_cnt < TO - 1) idle_cnt++;
                end else begin
                    idle_cnt = 0;
                end
            end
            P_ISSUE: begin
                if (pop) begin
                    left_cnt--;
                    new_last = (left_cnt == 0);
                    if (left_cnt == 0) ph = P_DRAIN;
                end
            end
            default: begin
                if (acc && exp_q[0][W]) ph = P_IDLE;
            end
        endcase
        if (acc) void'(exp_q.pop_front());
        if (pop) exp_q.push_back({new_last, fq[0]});
    endtask

    // One clock: present FIFO, compare DUT to model, advance model and FIFO.
    task automatic step();
        bit exp_rd, exp_v, rd_now;
        fifo_empty = (fq.size() == 0);
        fifo_count = CW'(fq.size());
        fifo_dout  = fifo_empty ? '0 : fq[0];
        #1;
        exp_v  = (exp_q.size() != 0);
        exp_rd = (ph == P_ISSUE) && (fq.size() != 0) && (exp_q.size() < 2);
        check_bit("fifo_rd_en", fifo_rd_en, exp_rd);
        check_bit("m_valid", m_valid, exp_v);
        check_bit("busy", busy, ph != P_IDLE);
        if (exp_v) begin
            check_val("m_data", m_data, exp_q[0][W-1:0]);
            check_bit("m_last", m_last, exp_q[0][W]);
        end
        check_bit("rd_while_empty", fifo_rd_en & fifo_empty, 1'b0);
        if (rd0 | v0 | b0 | l0) noflush_active = 1'b1;

        rd_now = fifo_rd_en;
        if (fifo_rd_en) begin
            if (rd_cnt == 0) first_rd_cyc = cyc;
            rd_cnt++;
        end
        if (m_valid && m_ready && !rst) begin
            acc_q.push_back({m_last, m_data});
            if (acc_q.size() == 1) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            burst_beats++;
            check_bit("burst_not_too_long", burst_beats <= BL, 1'b1);
            if (burst_beats == BL) check_bit("last_at_max_len", m_last, 1'b1);
            if (m_last) burst_beats = 0;
        end
        if (rst) burst_beats = 0;

        model_update(exp_rd, exp_v && m_ready);
        @(posedge clk);
        if (rst) fq.delete();
        else if (rd_now && fq.size() != 0) void'(fq.pop_front());
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rate;
        rst = 1'b1; enable = 1'b0; m_ready = 1'b0;
        fifo_empty = 1'b1; fifo_count = '0; fifo_dout = '0;
        ph = P_IDLE; left_cnt = 0; idle_cnt = 0;
        n_cmp = 0; n_err = 0; cyc = 0; burst_beats = 0; noflush_active = 1'b0;
        clear_stats();
        @(posedge clk);
        @(negedge clk);
        repeat (3) step();
        rst = 1'b0;

        // Reset values
        check_bit("reset_m_valid", m_valid, 1'b0);
        check_bit("reset_m_last", m_last, 1'b0);
        check_val("reset_m_data", m_data, 32'h0);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_fifo_rd_en", fifo_rd_en, 1'b0);

        // Full burst, m_ready high
        clear_stats();
        for (int i = 0; i < 8; i++) fq.push_back(32'h10 + i);
        enable = 1'b1; m_ready = 1'b1;
        repeat (12) step();
        check_val("full_rd_cnt", rd_cnt, 8);
        check_val("full_beats", acc_q.size(), 8);
        for (int i = 0; i < acc_q.size(); i++) begin
            check_val("full_data", acc_q[i][W-1:0], 32'h10 + i);
            check_bit("full_last", acc_q[i][W], i == 7);
        end
        check_val("full_first_pop_latency", first_rd_cyc - base, 1);
        check_val("full_consecutive", last_acc_cyc - first_acc_cyc, 7);
        check_bit("full_busy_end", busy, 1'b0);

        // Backpressure: m_ready toggles every cycle
        clear_stats();
        for (int i = 0; i < 16; i++) fq.push_back(32'h20 + i);
        for (int i = 0; i < 60; i++) begin
            m_ready = (i % 2 == 0);
            step();
        end
        check_val("bp_beats", acc_q.size(), 16);
        check_val("bp_rd_cnt", rd_cnt, 16);
        for (int i = 0; i < acc_q.size(); i++) begin
            check_val("bp_data", acc_q[i][W-1:0], 32'h20 + i);
            check_bit("bp_last", acc_q[i][W], (i == 7) || (i == 15));
        end

        // Timeout flush of a 3-word level
        m_ready = 1'b1;
        clear_stats();
        for (int i = 0; i < 3; i++) fq.push_back(32'h30 + i);
        repeat (80) step();
        check_val("timeout_first_pop", first_rd_cyc - base, 64);
        check_val("timeout_beats", acc_q.size(), 3);
        for (int i = 0; i < acc_q.size(); i++) begin
            check_val("timeout_data", acc_q[i][W-1:0], 32'h30 + i);
            check_bit("timeout_last", acc_q[i][W], i == 2);
        end
        check_bit("noflush_never_active", noflush_active, 1'b0);

        // enable gating
        enable = 1'b0;
        clear_stats();
        for (int i = 0; i < 12; i++) fq.push_back(32'h40 + i);
        repeat (20) step();
        check_val("gated_no_pop", rd_cnt, 0);
        enable = 1'b1;
        for (int i = 0; i < 40 && acc_q.size() < 4; i++) step();
        check_val("gated_beat4_reached", acc_q.size(), 4);
        enable = 1'b0;
        repeat (100) step();
        check_val("gated_beats", acc_q.size(), 8);
        check_val("gated_rd_cnt", rd_cnt, 8);
        for (int i = 0; i < acc_q.size(); i++) begin
            check_val("gated_data", acc_q[i][W-1:0], 32'h40 + i);
            check_bit("gated_last", acc_q[i][W], i == 7);
        end
        check_val("gated_left_in_fifo", fq.size(), 4);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;

        // Reset in ISSUE with two beats buffered
        enable = 1'b1; m_ready = 1'b0;
        clear_stats();
        for (int i = 0; i < 8; i++) fq.push_back(32'h50 + i);
        repeat (3) step();
        check_bit("pre_reset_valid", m_valid, 1'b1);
        check_bit("pre_reset_busy", busy, 1'b1);
        check_val("pre_reset_pops", rd_cnt, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_bit("post_reset_valid", m_valid, 1'b0);
        check_bit("post_reset_last", m_last, 1'b0);
        check_bit("post_reset_busy", busy, 1'b0);
        check_bit("post_reset_rd_en", fifo_rd_en, 1'b0);
        m_ready = 1'b1;
        clear_stats();
        for (int i = 0; i < 8; i++) fq.push_back(32'h60 + i);
        repeat (12) step();
        check_val("after_reset_beats", acc_q.size(), 8);
        for (int i = 0; i < acc_q.size(); i++) begin
            check_val("after_reset_data", acc_q[i][W-1:0], 32'h60 + i);
            check_bit("after_reset_last", acc_q[i][W], i == 7);
        end

        // Random traffic with varying write rate and backpressure
        for (int seg = 0; seg < 10; seg++) begin
            case ($urandom_range(0, 3))
                0:       rate = 3;
                1:       rate = 25;
                2:       rate = 60;
                default: rate = 95;
            endcase
            for (int i = 0; i < 1000; i++) begin
                if ($urandom_range(0, 99) < rate && fq.size() < DEPTH) fq.push_back($urandom);
                m_ready = ($urandom_range(0, 99) < 70);
                enable  = ($urandom_range(0, 99) < 95);
                step();
            end
        end

        // Drain everything left, including a final timeout flush
        enable = 1'b1; m_ready = 1'b1;
        repeat (300) step();
        check_val("drain_fifo_empty", fq.size(), 0);
        check_bit("drain_m_valid", m_valid, 1'b0);
        check_bit("drain_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
